hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Generates stall_i for the ID-stage control decoder and the write enables for PC and IF/ID.
//  Detects load-use hazards and ID-stage branch operand hazards from the EX/MEM pipeline contents.
//  Freezes the whole pipeline while the data memory is busy (handshake wait), with a timeout.
//  Keeps saturating performance counters of bubble cycles and freeze cycles.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive dmem wait cycles before abort (>=1)
//  CNT_W        32  width of performance counters
// PORTS
//  clk            in   1      core clock; all state updates on rising edge
//  rst            in   1      synchronous reset, active-high
//  id_rs1         in   5      rs1 field of instruction in ID
//  id_rs2         in   5      rs2 field of instruction in ID
//  id_use_rs1     in   1      ID instruction reads rs1
//  id_use_rs2     in   1      ID instruction reads rs2
//  id_branch      in   1      ID instruction is SB-type (compares in ID)
//  ex_rd          in   5      destination reg in ID/EX
//  ex_regwrite    in   1      ID/EX regwrite
//  ex_memread     in   1      ID/EX memread (load in EX)
//  mem_rd         in   5      destination reg in EX/MEM
//  mem_memread    in   1      EX/MEM memread
//  mem_memwrite   in   1      EX/MEM memwrite
//  dmem_ready     in   1      data memory completes current access this cycle
//  stall_o        out  1      bubble request -> decoder stall_i (zeroes ID/EX controls)
//  pc_write_o     out  1      PC register enable
//  ifid_write_o   out  1      IF/ID register enable
//  freeze_o       out  1      hold ID/EX, EX/MEM, MEM/WB registers
//  mem_err_o      out  1      one-cycle pulse on dmem timeout
//  stall_cnt_o    out  CNT_W  count of cycles with stall_o=1 (saturating)
//  freeze_cnt_o   out  CNT_W  count of cycles with freeze_o=1 (saturating)
// BEHAVIOUR
//  Match helpers: mEX = ex_rd!=0 & ((id_use_rs1&id_rs1==ex_rd)|(id_use_rs2&id_rs2==ex_rd));
//   mMEM likewise on mem_rd. x0 never causes a hazard.
//  Hazard (combinational, same cycle): hz = (ex_memread&mEX)
//   | (id_branch&ex_regwrite&mEX) | (id_branch&mem_memread&mMEM).
//   Load then dependent branch therefore gives 2 bubbles; ALU op then branch gives 1.
//  FSM states: RUN, MEM_WAIT. Reset -> RUN.
//   RUN: memreq=(mem_memread|mem_memwrite). memreq&!dmem_ready -> MEM_WAIT, wait_cnt<=1.
//   MEM_WAIT: dmem_ready -> RUN; else wait_cnt==MEM_TIMEOUT -> RUN, mem_err_o=1 one cycle;
//    else wait_cnt++. wait_cnt is clog2(MEM_TIMEOUT+1) bits, cleared on RUN entry.
//  Freeze: freeze_o = memreq&!dmem_ready (in RUN or MEM_WAIT), combinational.
//   Timeout cycle: freeze_o=0 (access abandoned, pipeline advances).
//  Priority: freeze over hazard. When freeze_o=1: stall_o=0, pc_write_o=0, ifid_write_o=0.
//   Else hz: stall_o=1, pc_write_o=0, ifid_write_o=0. Else stall_o=0, pc/ifid write=1.
//  Flush interplay: decoder suppresses if_flush while stall_i=1; this block does not flush.
//  Counters: +1 per cycle of stall_o / freeze_o, hold at all-ones (no wrap).
//  Reset (rst=1 at edge): state RUN, wait_cnt=0, counters=0, mem_err_o=0.
//   During rst cycle outputs forced: stall_o=0, freeze_o=0, pc_write_o=1, ifid_write_o=1.
//   Reset mid-MEM_WAIT aborts the wait with no mem_err_o pulse.
//  Latency: stall/freeze outputs 0-cycle (comb); mem_err_o and counters registered (1 cycle).
// TESTING
//  ex_memread=1,ex_rd=5,id_rs1=5,id_use_rs1=1 -> stall_o=1,pc_write_o=0 one cycle; stall_cnt=1.
//  Same with ex_rd=0 -> no stall; id_use_rs2=0,id_rs2=ex_rd=7 -> no stall.
//  Load x3 then beq x3 -> stall_o=1 two consecutive cycles; add x3 then beq -> exactly one.
//  mem_memread=1,dmem_ready=0 for 3 cycles then 1 -> freeze_o=1 3 cycles, freeze_cnt=3, no err.
//  dmem_ready held 0, MEM_TIMEOUT=4 -> freeze 4 cycles, mem_err_o pulse, state RUN.
//  Load-use hazard during freeze -> stall_o=0 until ready; rst mid-wait -> RUN, counters 0.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard and data-memory freeze controller: load-use and ID-branch operand
// bubbles, whole-pipeline freeze on dmem wait with timeout, saturating activity counters.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | no outstanding dmem wait; hazards evaluated normally
//   MEM_WAIT | dmem access pending, wait_cnt counts wait cycles to timeout
module hazard_stall_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_branch,
   input  logic [4:0]       ex_rd,
   input  logic             ex_regwrite,
   input  logic             ex_memread,
   input  logic [4:0]       mem_rd,
   input  logic             mem_memread,
   input  logic             mem_memwrite,
   input  logic             dmem_ready,
   output logic             stall_o,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             freeze_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] freeze_cnt_o
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   state_t          state, state_nxt;
   logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
   logic            m_ex, m_mem, hz, memreq, timeout;

   always_comb begin
      m_ex  = (ex_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
      m_mem = (mem_rd != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == mem_rd)) || (id_use_rs2 && (id_rs2 == mem_rd)));
      hz    = (ex_memread && m_ex) ||
              (id_branch && ex_regwrite && m_ex) ||
              (id_branch && mem_memread && m_mem);
      memreq = mem_memread || mem_memwrite;
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      timeout      = 1'b0;
      case (state)
         RUN: begin
            wait_cnt_nxt = '0;
            if (memreq && !dmem_ready) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = WC_W'(1);
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == WC_MAX) begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
               timeout      = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
         end
      endcase
   end

   // On the timeout cycle the access is abandoned, so the pipeline is released.
   always_comb begin
      freeze_o     = !rst && memreq && !dmem_ready && !timeout;
      stall_o      = !rst && !freeze_o && hz;
      pc_write_o   = !(freeze_o || stall_o);
      ifid_write_o = !(freeze_o || stall_o);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         wait_cnt     <= '0;
         mem_err_o    <= 1'b0;
         stall_cnt_o  <= '0;
         freeze_cnt_o <= '0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         mem_err_o <= timeout;
         if (stall_o && (stall_cnt_o != '1))
            stall_cnt_o <= stall_cnt_o + 1'b1;
         if (freeze_o && (freeze_cnt_o != '1))
            freeze_cnt_o <= freeze_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: the driver queues hand-derived expectations
// per cycle, a monitor on the falling edge pops and compares them.
module tb_hazard_stall_ctrl;

   localparam int TO = 4;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    id_rs1, id_rs2, ex_rd, mem_rd;
   logic          id_use_rs1, id_use_rs2, id_branch;
   logic          ex_regwrite, ex_memread, mem_memread, mem_memwrite, dmem_ready;
   logic          stall_o, pc_write_o, ifid_write_o, freeze_o, mem_err_o;
   logic [CW-1:0] stall_cnt_o, freeze_cnt_o;

   hazard_stall_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_branch(id_branch), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_rd(mem_rd), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
      .dmem_ready(dmem_ready), .stall_o(stall_o), .pc_write_o(pc_write_o),
      .ifid_write_o(ifid_write_o), .freeze_o(freeze_o), .mem_err_o(mem_err_o),
      .stall_cnt_o(stall_cnt_o), .freeze_cnt_o(freeze_cnt_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic          stall, pcw, frz, err;
      logic [CW-1:0] scnt, fcnt;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   es_cnt   = 0;
   int   ef_cnt   = 0;

   task automatic chk(input string name, input string what, input logic [CW-1:0] act,
                      input logic [CW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0h expected %0h at %0t", name, what, act, exp, $time);
      end
   endtask

   // Monitor: one expectation per driven cycle, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "stall",  CW'(stall_o),      CW'(e.stall));
            chk(e.name, "pcw",    CW'(pc_write_o),   CW'(e.pcw));
            chk(e.name, "ifidw",  CW'(ifid_write_o), CW'(e.pcw));
            chk(e.name, "freeze", CW'(freeze_o),     CW'(e.frz));
            chk(e.name, "err",    CW'(mem_err_o),    CW'(e.err));
            chk(e.name, "scnt",   stall_cnt_o,       e.scnt);
            chk(e.name, "fcnt",   freeze_cnt_o,      e.fcnt);
         end
      end
   end

   task automatic idle();
      id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_branch = 0;
      ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
      mem_rd = 0; mem_memread = 0; mem_memwrite = 0; dmem_ready = 1;
   endtask

   // Queue expectation for the current cycle's inputs, then advance one clock.
   task automatic cyc(input string name, input bit s, input bit f, input bit e);
      exp_t x;
      x.name = name; x.stall = s; x.frz = f; x.err = e; x.pcw = !(s || f);
      x.scnt = CW'(es_cnt); x.fcnt = CW'(ef_cnt);
      q.push_back(x);
      @(posedge clk); #1;
      if (rst) begin
         es_cnt = 0; ef_cnt = 0;
      end else begin
         if (s && es_cnt != (1 << CW) - 1) es_cnt++;
         if (f && ef_cnt != (1 << CW) - 1) ef_cnt++;
      end
   endtask

   initial begin
      rst = 1; idle();
      @(posedge clk); #1;

      // reset forces outputs even with a hazard and a pending dmem access
      ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; mem_memread = 1; dmem_ready = 0;
      cyc("rst_forced", 0, 0, 0);
      rst = 0; idle();
      cyc("idle", 0, 0, 0);

      ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
      cyc("load_use", 1, 0, 0);
      idle();
      cyc("after_load_use", 0, 0, 0);

      ex_memread = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
      cyc("x0_no_hz", 0, 0, 0);
      idle(); ex_memread = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 0;
      cyc("rs2_unused", 0, 0, 0);
      id_use_rs2 = 1;
      cyc("rs2_used", 1, 0, 0);
      idle(); ex_regwrite = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
      cyc("alu_no_branch", 0, 0, 0);

      // load x3 ; beq x3 -> two bubbles
      idle(); ex_memread = 1; ex_regwrite = 1; ex_rd = 3; id_branch = 1; id_rs1 = 3; id_use_rs1 = 1;
      cyc("ld_br_1", 1, 0, 0);
      idle(); id_branch = 1; id_rs1 = 3; id_use_rs1 = 1; mem_memread = 1; mem_rd = 3;
      cyc("ld_br_2", 1, 0, 0);
      idle(); id_branch = 1; id_rs1 = 3; id_use_rs1 = 1;
      cyc("ld_br_3", 0, 0, 0);

      // add x3 ; beq x3 -> one bubble
      idle(); ex_regwrite = 1; ex_rd = 3; id_branch = 1; id_rs2 = 3; id_use_rs2 = 1;
      cyc("alu_br_1", 1, 0, 0);
      idle(); mem_rd = 3; id_branch = 1; id_rs2 = 3; id_use_rs2 = 1;
      cyc("alu_br_2", 0, 0, 0);

      // 3-cycle dmem wait, no error
      idle(); mem_memread = 1; dmem_ready = 0;
      for (int i = 0; i < 3; i++) cyc("frz3", 0, 1, 0);
      dmem_ready = 1;
      cyc("frz3_done", 0, 0, 0);
      idle();
      cyc("frz3_no_err", 0, 0, 0);

      // timeout: 4 freeze cycles, released on the 5th, error pulse after
      mem_memread = 1; dmem_ready = 0;
      for (int i = 0; i < TO; i++) cyc("to_frz", 0, 1, 0);
      cyc("to_cycle", 0, 0, 0);
      idle();
      cyc("to_err", 0, 0, 1);
      cyc("to_err_end", 0, 0, 0);

      // hazard during freeze is masked until dmem is ready
      mem_memwrite = 1; dmem_ready = 0; ex_memread = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1;
      cyc("hz_frz_1", 0, 1, 0);
      cyc("hz_frz_2", 0, 1, 0);
      dmem_ready = 1;
      cyc("hz_after_frz", 1, 0, 0);

      // reset mid-wait: no error, counters cleared, wait count restarts
      idle(); mem_memread = 1; dmem_ready = 0;
      for (int i = 0; i < 3; i++) cyc("pre_rst_frz", 0, 1, 0);
      rst = 1;
      cyc("rst_mid_wait", 0, 0, 0);
      rst = 0;
      for (int i = 0; i < TO; i++) cyc("post_rst_frz", 0, 1, 0);
      cyc("post_rst_to", 0, 0, 0);
      idle();
      cyc("post_rst_err", 0, 0, 1);

      // back-to-back timeouts drive the freeze counter into saturation
      mem_memread = 1; dmem_ready = 0;
      for (int ep = 0; ep < 4; ep++) begin
         for (int k = 0; k < TO; k++) cyc("fsat", 0, 1, (k == 0 && ep > 0));
         cyc("fsat_to", 0, 0, 0);
      end
      idle();
      cyc("fsat_end", 0, 0, 1);

      // held load-use hazard drives the stall counter into saturation
      ex_memread = 1; ex_rd = 12; id_rs1 = 12; id_use_rs1 = 1;
      for (int i = 0; i < 20; i++) cyc("ssat", 1, 0, 0);
      idle();
      cyc("ssat_end", 0, 0, 0);
      cyc("final", 0, 0, 0);

      repeat (2) @(posedge clk);
      chk("drain", "queue_left", CW'(q.size()), CW'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
